alu_result_stage: RTL

Execute-stage result register sitting directly downstream of the combinational ALU. It accepts an opcode plus operands, drives the ALU carry-in from its flag register, selects the required ALU output, and computes N/Z/C/V flags; the ALU itself does not produce overflow or other flags. Results go to the register-file writeback port over a valid/ready handshake. Long multiply (MULL) is emitted as two writeback beats.

---
 rtl/alu_result_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// Execute-stage result register behind the combinational ALU.
// Selects the ALU result, maintains N/Z/C/V flags and drives writeback over a valid/ready handshake.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int RDW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [RDW-1:0]   rd,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             alu_carry,
    input  logic [WIDTH-1:0] summ,
    input  logic             ocarry,
    input  logic [WIDTH-1:0] mult_h,
    input  logic [WIDTH-1:0] mult_l,
    input  logic [WIDTH-1:0] zand,
    input  logic [WIDTH-1:0] zor,
    input  logic [WIDTH-1:0] zxor,
    input  logic [WIDTH-1:0] znot,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [RDW-1:0]   wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       flags,
    output logic             flags_upd,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, BEAT, HI} state_t;

    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    state_t           state, state_nxt;
    logic             held_mull;
    logic [WIDTH-1:0] hi_data;
    logic [RDW-1:0]   hi_rd;
    logic             accept, legal, take;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && legal) state_nxt = BEAT;
            BEAT: begin
                if (take) begin
                    if (held_mull)             state_nxt = HI;
                    else if (accept && legal)  state_nxt = BEAT;
                    else                       state_nxt = IDLE;
                end
            end
            HI:   if (take) state_nxt = (accept && legal) ? BEAT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A held MULL low beat also blocks input: its high beat must follow immediately.
    always_comb begin
        wb_valid  = (state != IDLE);
        in_ready  = (state != HI) && !(state == BEAT && held_mull) && (!wb_valid || wb_ready);
        alu_carry = (op == 4'd1) && flags[FC];
    end

    assign take   = wb_valid && wb_ready;
    assign accept = in_valid && in_ready;
    assign legal  = !op[3];

    always_comb begin
        result = '0;
        case (op)
            4'd0, 4'd1: result = summ;
            4'd2:       result = zand;
            4'd3:       result = zor;
            4'd4:       result = zxor;
            4'd5:       result = znot;
            4'd6, 4'd7: result = mult_l;
            default:    result = '0;
        endcase
    end

    always_comb begin
        flags_nxt     = flags;
        flags_nxt[FN] = result[WIDTH-1];
        flags_nxt[FZ] = (result == '0);
        if (op == 4'd0 || op == 4'd1) begin
            flags_nxt[FC] = ocarry;
            flags_nxt[FV] = (x[WIDTH-1] == y[WIDTH-1]) && (summ[WIDTH-1] != x[WIDTH-1]);
        end else if (op == 4'd7) begin
            flags_nxt[FN] = mult_h[WIDTH-1];
            flags_nxt[FZ] = (mult_h == '0) && (mult_l == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd     <= '0;
            wb_data   <= '0;
            hi_rd     <= '0;
            hi_data   <= '0;
            held_mull <= 1'b0;
            flags     <= '0;
            flags_upd <= 1'b0;
            err       <= 1'b0;
        end else begin
            flags_upd <= accept && legal && set_flags;
            err       <= accept && !legal;
            if (accept && legal && set_flags) begin
                flags <= flags_nxt;
            end
            if (accept && legal) begin
                wb_rd     <= rd;
                wb_data   <= result;
                hi_rd     <= rd + RDW'(1);
                hi_data   <= mult_h;
                held_mull <= (op == 4'd7);
            end else if (take && held_mull && state == BEAT) begin
                wb_rd     <= hi_rd;
                wb_data   <= hi_data;
                held_mull <= 1'b0;
            end
        end
    end

endmodule
